spi_eeprom_responder: RTL



---
 rtl/spi_eeprom_responder_if.sv | 27 ++
 rtl/spi_eeprom_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_eeprom_responder_if.sv
// SPI pin bundle plus host-side byte-fetch handshake for spi_eeprom_responder.
// slave = responder side, master = initiator/host side.
interface spi_eeprom_responder_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              spi_cs_n;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [7:0]        rd_data;
    logic              busy;
    logic              underrun;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, rd_ack, rd_data,
        output spi_miso, spi_miso_oe, rd_req, rd_addr, busy, underrun
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, rd_ack, rd_data,
        input  spi_miso, spi_miso_oe, rd_req, rd_addr, busy, underrun
    );
endinterface

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 serial-EEPROM read responder (READ 0x03, RDSR 0x05), pins oversampled in clk.
// Define SPI_RESP_FASTREAD_EN to also accept FAST_READ (0x0B) with an 8-bit-time dummy phase.
module spi_eeprom_responder #(
    parameter int unsigned ADDR_W      = 24,
    parameter logic [7:0]  STATUS_BYTE = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                   clk,
    input logic                   rst,
    spi_eeprom_responder_if.slave bus
);
    localparam int unsigned CntW = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StData, StStatus, StIgnore
`ifdef SPI_RESP_FASTREAD_EN
        , StDummy
`endif
    } state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]      sh_q, sh_d;
    logic [7:0]             tx_q, tx_d;
    logic [2:0]             tx_cnt_q, tx_cnt_d;
    logic                   miso_q, miso_d;
    logic                   rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [7:0]             buf_q, buf_d;
    logic                   buf_vld_q, buf_vld_d;
    logic                   underrun_q, underrun_d;
`ifdef SPI_RESP_FASTREAD_EN
    logic                   fast_q, fast_d;
`endif

    logic       cs_s, sclk_s, mosi_s;
    logic       cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic       shift_en, load_en;
    logic [7:0] load_val;

    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        tx_cnt_d   = tx_cnt_q;
        miso_d     = miso_q;
        rd_req_d   = rd_req_q;
        rd_addr_d  = rd_addr_q;
        buf_d      = buf_q;
        buf_vld_d  = buf_vld_q;
        underrun_d = underrun_q;
        shift_en   = 1'b0;
        load_en    = 1'b0;
        load_val   = 8'hFF;
`ifdef SPI_RESP_FASTREAD_EN
        fast_d     = fast_q;
`endif

        if (rd_req_q && bus.rd_ack) begin
            buf_d     = bus.rd_data;
            buf_vld_d = 1'b1;
            rd_req_d  = 1'b0;
        end

        // Deselect wins over everything, including an ack landing in the same cycle.
        if (cs_rise) begin
            state_d   = StIdle;
            miso_d    = 1'b1;
            rd_req_d  = 1'b0;
            buf_vld_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
`ifdef SPI_RESP_FASTREAD_EN
                        fast_d    = 1'b0;
`endif
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        sh_d      = {sh_q[ADDR_W-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == CntW'(7)) begin
                            bit_cnt_d = '0;
                            tx_cnt_d  = '0;
                            case ({sh_q[6:0], mosi_s})
                                8'h03: state_d = StAddr;
                                8'h05: state_d = StStatus;
`ifdef SPI_RESP_FASTREAD_EN
                                8'h0B: begin
                                    state_d = StAddr;
                                    fast_d  = 1'b1;
                                end
`endif
                                default: state_d = StIgnore;
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        sh_d      = {sh_q[ADDR_W-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == CntW'(ADDR_W - 1)) begin
                            bit_cnt_d = '0;
                            tx_cnt_d  = '0;
                            rd_addr_d = {sh_q[ADDR_W-2:0], mosi_s};
                            rd_req_d  = 1'b1;
                            buf_vld_d = 1'b0;
`ifdef SPI_RESP_FASTREAD_EN
                            state_d   = fast_q ? StDummy : StData;
`else
                            state_d   = StData;
`endif
                        end
                    end
                end
`ifdef SPI_RESP_FASTREAD_EN
                StDummy: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                        if (bit_cnt_q == CntW'(7)) begin
                            bit_cnt_d = '0;
                            state_d   = StData;
                        end
                    end
                end
`endif
                StData: begin
                    if (sclk_fall) begin
                        shift_en = 1'b1;
                        load_en  = (tx_cnt_q == 3'd0);
                        if (load_en) begin
                            // An ack in the very cycle the byte is needed is used directly.
                            if (buf_vld_q) begin
                                load_val = buf_q;
                            end else if (rd_req_q && bus.rd_ack) begin
                                load_val = bus.rd_data;
                            end else begin
                                load_val   = 8'hFF;
                                underrun_d = 1'b1;
                            end
                            buf_vld_d = 1'b0;
                            rd_addr_d = rd_addr_q + ADDR_W'(1);
                            rd_req_d  = 1'b1;
                        end
                    end
                end
                StStatus: begin
                    if (sclk_fall) begin
                        shift_en = 1'b1;
                        load_en  = (tx_cnt_q == 3'd0);
                        load_val = STATUS_BYTE;
                    end
                end
                StIgnore: ;
                default: state_d = StIdle;
            endcase
        end

        if (shift_en) begin
            if (load_en) begin
                {miso_d, tx_d} = {load_val, 1'b1};
            end else begin
                {miso_d, tx_d} = {tx_q, 1'b1};
            end
            tx_cnt_d = tx_cnt_q + 3'd1;
        end
    end

    // cs_n sync resets to "selected" so a frame already in progress at reset is not picked up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            tx_q        <= 8'hFF;
            tx_cnt_q    <= '0;
            miso_q      <= 1'b1;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            buf_q       <= '0;
            buf_vld_q   <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef SPI_RESP_FASTREAD_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            tx_q        <= tx_d;
            tx_cnt_q    <= tx_cnt_d;
            miso_q      <= miso_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            underrun_q  <= underrun_d;
`ifdef SPI_RESP_FASTREAD_EN
            fast_q      <= fast_d;
`endif
        end
    end

    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = (state_q == StData) || (state_q == StStatus);
    assign bus.rd_req      = rd_req_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.underrun    = underrun_q;
endmodule
